// File: rtl/mini_bit_pkg.sv
// Shared types and helpers for the mini_bit serial blocks.
// Parity support in consumers is enabled by MINI_BIT_TX_SINK_PARITY_EN.
package mini_bit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } mb_state_e;

  localparam int MB_DATA_BITS = 8;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic mb_even_parity(input logic [MB_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mini_bit_fifo.sv
// Synchronous FIFO with occupancy count and a registered head entry.
// Shared by the mini_bit serial sink and future tx sources.
module mini_bit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_next;
  logic          pop_ok;
  logic          push_ok;
  logic [CW-1:0] count_kept;
  logic [CW-1:0] count_next;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign pop_ok     = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign push_ok    = push && (!full || pop_ok);
  assign rd_next    = rd_ptr + PW'(pop_ok);
  assign count_kept = count - CW'(pop_ok);
  assign count_next = count_kept + CW'(push_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_ptr + PW'(push_ok);
      count  <= count_next;
      // Head is loaded from the incoming byte when it becomes the only entry.
      if (push_ok && (count_kept == '0)) head <= push_data;
      else if (count_next != '0)         head <= mem[rd_next];
    end
  end

endmodule

// File: rtl/mini_bit_tx_sink.sv
// Deserialises 8N1 frames from the mini_bit tx line into a FIFO with sticky errors.
// Define MINI_BIT_TX_SINK_PARITY_EN for 8E1 frames and the parity_err flag.
module mini_bit_tx_sink
  import mini_bit_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tx,
  output logic [7:0]             data_out,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic                   frame_err,
  output logic                   overrun,
`ifdef MINI_BIT_TX_SINK_PARITY_EN
  output logic                   parity_err,
`endif
  input  logic                   err_clear,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [2:0]             state_dbg
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IW    = $clog2(MB_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0]    IDX_LAST = IW'(MB_DATA_BITS - 1);

  logic sync1;
  logic s;

  mb_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [MB_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                  brk_q, brk_d;
  logic                  push_q, push_d;
  logic                  frame_set;
`ifdef MINI_BIT_TX_SINK_PARITY_EN
  logic                  par_bad_q, par_bad_d;
  logic                  par_set;
`endif

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic ovr_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      s     <= 1'b1;
    end else begin
      sync1 <= tx;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      brk_q     <= 1'b0;
      push_q    <= 1'b0;
`ifdef MINI_BIT_TX_SINK_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      brk_q     <= brk_d;
      push_q    <= push_d;
`ifdef MINI_BIT_TX_SINK_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    brk_d     = brk_q;
    push_d    = 1'b0;
    frame_set = 1'b0;
`ifdef MINI_BIT_TX_SINK_PARITY_EN
    par_bad_d = par_bad_q;
    par_set   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        brk_d = 1'b0;
`ifdef MINI_BIT_TX_SINK_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {s, shreg_q[MB_DATA_BITS-1:1]};
          idx_d   = idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef MINI_BIT_TX_SINK_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef MINI_BIT_TX_SINK_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_STOP;
          if (s != mb_even_parity(shreg_q)) begin
            par_set   = 1'b1;
            par_bad_d = 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        // After a low stop bit, park here until the line idles so a break flags once.
        if (brk_q) begin
          cnt_d = '0;
          if (s) begin
            brk_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (s) begin
`ifdef MINI_BIT_TX_SINK_PARITY_EN
            push_d = !par_bad_q;
`else
            push_d = 1'b1;
`endif
            state_d = ST_IDLE;
          end else begin
            frame_set = 1'b1;
            brk_d     = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop     = data_valid && data_ready;
  assign ovr_set = push_q && fifo_full && !pop;

  mini_bit_fifo #(
    .DEPTH(DEPTH),
    .W    (MB_DATA_BITS)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_q),
    .push_data(shreg_q),
    .pop      (pop),
    .head     (data_out),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign data_valid = !fifo_empty;
  assign state_dbg  = state_q;

  // Sticky flags: a set in the same cycle as err_clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef MINI_BIT_TX_SINK_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= frame_set | (frame_err & ~err_clear);
      overrun    <= ovr_set   | (overrun   & ~err_clear);
`ifdef MINI_BIT_TX_SINK_PARITY_EN
      parity_err <= par_set   | (parity_err & ~err_clear);
`endif
    end
  end

endmodule
